// File: rtl/riscv_test_monitor.sv
// Completion monitor for riscv-tests runs: detects pass/fail/timeout from the
// terminal-loop PC, a tohost store or a cycle budget, and reports the failing test number.
module riscv_test_monitor #(
  parameter int unsigned XLEN        = 32,
  parameter logic [31:0] PASS_PC     = 32'h44,
  parameter int unsigned PC_HOLD     = 1,
  parameter logic [31:0] TOHOST_ADDR = 32'h1000,
  parameter int unsigned MODE        = 2,
  parameter int unsigned TIMEOUT     = 6000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [XLEN-1:0]   if_pc,
  input  logic [XLEN-1:0]   gp,
  input  logic              st_valid,
  input  logic [XLEN-1:0]   st_addr,
  input  logic [XLEN-1:0]   st_data,
  output logic              done,
  output logic              passed,
  output logic              failed,
  output logic              timed_out,
  output logic [XLEN-2:0]   test_num,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_PASS    = 2'b01,
    ST_FAIL    = 2'b10,
    ST_TIMEOUT = 2'b11
  } state_t;

  localparam logic [XLEN-1:0]  PASS_PC_X = XLEN'(PASS_PC);
  localparam logic [XLEN-1:0]  TOHOST_X  = XLEN'(TOHOST_ADDR);
  localparam logic [XLEN-1:0]  ONE_X     = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 32'd1);
  localparam logic [3:0]       HOLD_L    = 4'(PC_HOLD);
  localparam bit               PC_EN     = (MODE == 32'd0) || (MODE == 32'd2);
  localparam bit               TH_EN     = (MODE == 32'd1) || (MODE == 32'd2);

  state_t            state_r, state_nxt_s;
  logic [3:0]        hold_r, hold_nxt_s, hold_inc_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s, cnt_inc_s;
  logic [XLEN-2:0]   num_r, num_nxt_s;
  logic              done_r, passed_r, failed_r, timed_out_r;
  logic              pc_match_s, pc_evt_s, th_evt_s, to_evt_s;
  logic              unused_s;

  // Byte offset within the tohost word does not matter.
  assign unused_s = ^st_addr[1:0];

  // Event detection for the current cycle.
  always_comb begin
    pc_match_s = (if_pc == PASS_PC_X);
    hold_inc_s = (hold_r == 4'hF) ? hold_r : hold_r + 4'd1;
    cnt_inc_s  = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_ONE;
    pc_evt_s   = PC_EN && en && pc_match_s && (hold_inc_s == HOLD_L);
    th_evt_s   = TH_EN && en && st_valid && st_data[0]
                 && (st_addr[XLEN-1:2] == TOHOST_X[XLEN-1:2]);
    to_evt_s   = en && (cnt_r == TO_LAST);
  end

  // Next-state logic; tohost beats the PC watch, which beats the timeout.
  always_comb begin
    state_nxt_s = state_r;
    hold_nxt_s  = hold_r;
    cnt_nxt_s   = cnt_r;
    num_nxt_s   = num_r;
    case (state_r)
      ST_RUN: begin
        if (en) begin
          cnt_nxt_s  = cnt_inc_s;
          hold_nxt_s = pc_match_s ? hold_inc_s : 4'd0;
          if (th_evt_s) begin
            if (st_data == ONE_X) begin
              state_nxt_s = ST_PASS;
            end else begin
              state_nxt_s = ST_FAIL;
              num_nxt_s   = st_data[XLEN-1:1];
            end
          end else if (pc_evt_s) begin
            if (gp == ONE_X) begin
              state_nxt_s = ST_PASS;
            end else begin
              state_nxt_s = ST_FAIL;
              num_nxt_s   = gp[XLEN-1:1];
            end
          end else if (to_evt_s) begin
            state_nxt_s = ST_TIMEOUT;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: begin
        state_nxt_s = state_r;
      end
    endcase
  end

  // State, counters and registered result flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_RUN;
      hold_r      <= 4'd0;
      cnt_r       <= {CNT_W{1'b0}};
      num_r       <= {(XLEN-1){1'b0}};
      done_r      <= 1'b0;
      passed_r    <= 1'b0;
      failed_r    <= 1'b0;
      timed_out_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      hold_r      <= hold_nxt_s;
      cnt_r       <= cnt_nxt_s;
      num_r       <= num_nxt_s;
      done_r      <= (state_nxt_s != ST_RUN);
      passed_r    <= (state_nxt_s == ST_PASS);
      failed_r    <= (state_nxt_s == ST_FAIL);
      timed_out_r <= (state_nxt_s == ST_TIMEOUT);
    end
  end

  assign done        = done_r;
  assign passed      = passed_r;
  assign failed      = failed_r;
  assign timed_out   = timed_out_r;
  assign test_num    = num_r;
  assign cycle_count = cnt_r;
  assign state       = state_r;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Self-checking bench: four monitor configurations share one stimulus stream and are
// compared every cycle against a rule-level model, plus directed vectors and sequences.
module tb_riscv_test_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, sv;
  logic [31:0] pc, gp, sa, sd;

  logic        done_w [4];
  logic        pass_w [4];
  logic        fail_w [4];
  logic        to_w   [4];
  logic [30:0] num_w  [4];
  logic [31:0] cnt_w  [4];
  logic [1:0]  st_w   [4];

  int cfg_mode [4] = '{2, 2, 1, 0};
  int cfg_hold [4] = '{1, 3, 2, 2};
  int cfg_tmo  [4] = '{6000, 10, 40, 50};

  riscv_test_monitor #(.MODE(2), .PC_HOLD(1), .TIMEOUT(6000)) u_a (
    .clk(clk), .rst(rst), .en(en), .if_pc(pc), .gp(gp), .st_valid(sv), .st_addr(sa), .st_data(sd),
    .done(done_w[0]), .passed(pass_w[0]), .failed(fail_w[0]), .timed_out(to_w[0]),
    .test_num(num_w[0]), .cycle_count(cnt_w[0]), .state(st_w[0]));
  riscv_test_monitor #(.MODE(2), .PC_HOLD(3), .TIMEOUT(10)) u_b (
    .clk(clk), .rst(rst), .en(en), .if_pc(pc), .gp(gp), .st_valid(sv), .st_addr(sa), .st_data(sd),
    .done(done_w[1]), .passed(pass_w[1]), .failed(fail_w[1]), .timed_out(to_w[1]),
    .test_num(num_w[1]), .cycle_count(cnt_w[1]), .state(st_w[1]));
  riscv_test_monitor #(.MODE(1), .PC_HOLD(2), .TIMEOUT(40)) u_c (
    .clk(clk), .rst(rst), .en(en), .if_pc(pc), .gp(gp), .st_valid(sv), .st_addr(sa), .st_data(sd),
    .done(done_w[2]), .passed(pass_w[2]), .failed(fail_w[2]), .timed_out(to_w[2]),
    .test_num(num_w[2]), .cycle_count(cnt_w[2]), .state(st_w[2]));
  riscv_test_monitor #(.MODE(0), .PC_HOLD(2), .TIMEOUT(50)) u_d (
    .clk(clk), .rst(rst), .en(en), .if_pc(pc), .gp(gp), .st_valid(sv), .st_addr(sa), .st_data(sd),
    .done(done_w[3]), .passed(pass_w[3]), .failed(fail_w[3]), .timed_out(to_w[3]),
    .test_num(num_w[3]), .cycle_count(cnt_w[3]), .state(st_w[3]));

  // Model: outcome (0 run, 1 pass, 2 fail, 3 timeout), enabled run cycles, PC streak length.
  typedef struct {
    int          st;
    longint      cnt;
    int          run;
    logic [30:0] num;
  } mdl_t;
  mdl_t m [4];

  typedef struct {
    logic        rst, en;
    logic [31:0] pc, gp;
    logic        sv;
    logic [31:0] sa, sd;
    logic [1:0]  st;
    logic [30:0] num;
    logic [31:0] cnt;
  } vec_t;
  vec_t tbl [17];

  int n_checks;
  int n_err;

  function automatic mdl_t step(mdl_t c, int mode, int hold, int tmo);
    mdl_t n = c;
    bit th, pe;
    if (rst) begin
      n.st = 0; n.cnt = 0; n.run = 0; n.num = '0;
      return n;
    end
    if (n.st != 0 || !en) return n;
    n.cnt = n.cnt + 1;
    n.run = (pc == 32'h44) ? n.run + 1 : 0;
    th = (mode != 0) && sv && (sa[31:2] == 30'h400) && sd[0];
    pe = (mode != 1) && (n.run == hold);
    if (th) begin
      if (sd == 32'd1) n.st = 1;
      else begin n.st = 2; n.num = sd[31:1]; end
    end else if (pe) begin
      if (gp == 32'd1) n.st = 1;
      else begin n.st = 2; n.num = gp[31:1]; end
    end else if (n.cnt == longint'(tmo)) begin
      n.st = 3;
    end
    return n;
  endfunction

  function automatic logic [68:0] expv(int st, logic [30:0] num, logic [31:0] cnt);
    logic [1:0] s = st[1:0];
    return {st != 0, st == 1, st == 2, st == 3, s, num, cnt};
  endfunction

  function automatic logic [68:0] actv(int i);
    return {done_w[i], pass_w[i], fail_w[i], to_w[i], st_w[i], num_w[i], cnt_w[i]};
  endfunction

  task automatic check(string name, logic [68:0] act, logic [68:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (done,pass,fail,to,state,num,cnt)", name, act, exp);
    end
  endtask

  task automatic drive(logic r, logic e, logic [31:0] p, logic [31:0] g,
                       logic v, logic [31:0] a, logic [31:0] d);
    rst = r; en = e; pc = p; gp = g; sv = v; sa = a; sd = d;
  endtask

  task automatic cyc();
    @(posedge clk);
    for (int i = 0; i < 4; i++) m[i] = step(m[i], cfg_mode[i], cfg_hold[i], cfg_tmo[i]);
    #1;
    for (int i = 0; i < 4; i++)
      check($sformatf("model_u%0d", i), actv(i), expv(m[i].st, m[i].num, 32'(m[i].cnt)));
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    for (int i = 0; i < 4; i++) m[i] = '{0, 0, 0, '0};

    tbl[0]  = '{1'b1, 1'b0, 32'h0,  32'h0,  1'b0, 32'h0,    32'h0, 2'd0, 31'd0, 32'd0};
    tbl[1]  = '{1'b0, 1'b1, 32'h0,  32'h0,  1'b0, 32'h0,    32'h0, 2'd0, 31'd0, 32'd1};
    tbl[2]  = '{1'b0, 1'b1, 32'h44, 32'h0B, 1'b0, 32'h0,    32'h0, 2'd2, 31'd5, 32'd2};
    tbl[3]  = '{1'b0, 1'b1, 32'h0,  32'h0,  1'b1, 32'h1000, 32'h1, 2'd2, 31'd5, 32'd2};
    tbl[4]  = '{1'b1, 1'b1, 32'h0,  32'h0,  1'b0, 32'h0,    32'h0, 2'd0, 31'd0, 32'd0};
    tbl[5]  = '{1'b0, 1'b1, 32'h44, 32'h1,  1'b1, 32'h1000, 32'h7, 2'd2, 31'd3, 32'd1};
    tbl[6]  = '{1'b1, 1'b0, 32'h0,  32'h0,  1'b0, 32'h0,    32'h0, 2'd0, 31'd0, 32'd0};
    tbl[7]  = '{1'b0, 1'b1, 32'h0,  32'h0,  1'b1, 32'h1000, 32'h2, 2'd0, 31'd0, 32'd1};
    tbl[8]  = '{1'b0, 1'b1, 32'h0,  32'h0,  1'b1, 32'h1003, 32'h1, 2'd1, 31'd0, 32'd2};
    tbl[9]  = '{1'b1, 1'b0, 32'h0,  32'h0,  1'b0, 32'h0,    32'h0, 2'd0, 31'd0, 32'd0};
    tbl[10] = '{1'b0, 1'b0, 32'h44, 32'h1,  1'b0, 32'h0,    32'h0, 2'd0, 31'd0, 32'd0};
    tbl[11] = '{1'b0, 1'b1, 32'h0,  32'h0,  1'b1, 32'h1004, 32'h3, 2'd0, 31'd0, 32'd1};
    tbl[12] = '{1'b0, 1'b1, 32'h44, 32'h0,  1'b0, 32'h0,    32'h0, 2'd2, 31'd0, 32'd2};
    tbl[13] = '{1'b1, 1'b1, 32'h44, 32'h1,  1'b0, 32'h0,    32'h0, 2'd0, 31'd0, 32'd0};
    tbl[14] = '{1'b0, 1'b1, 32'h44, 32'h1,  1'b0, 32'h0,    32'h0, 2'd1, 31'd0, 32'd1};
    tbl[15] = '{1'b1, 1'b0, 32'h0,  32'h0,  1'b0, 32'h0,    32'h0, 2'd0, 31'd0, 32'd0};
    tbl[16] = '{1'b0, 1'b1, 32'h44, 32'h1,  1'b0, 32'h0,    32'h0, 2'd1, 31'd0, 32'd1};

    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    cyc();

    // Directed vectors against the MODE 2 / PC_HOLD 1 instance.
    for (int k = 0; k < 17; k++) begin
      drive(tbl[k].rst, tbl[k].en, tbl[k].pc, tbl[k].gp, tbl[k].sv, tbl[k].sa, tbl[k].sd);
      cyc();
      check($sformatf("vec%0d", k), actv(0), expv(int'(tbl[k].st), tbl[k].num, tbl[k].cnt));
    end

    // PASS at RUN cycle 20.
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0); cyc();
    drive(1'b0, 1'b1, 32'h0, 32'h1, 1'b0, 32'h0, 32'h0);
    for (int k = 0; k < 20; k++) cyc();
    check("pass_pre", actv(0), expv(0, 31'd0, 32'd20));
    pc = 32'h44; cyc();
    check("pass_c21", actv(0), expv(1, 31'd0, 32'd21));

    // PC_HOLD=3: a broken streak of two, then a streak of three.
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0); cyc();
    drive(1'b0, 1'b1, 32'h44, 32'h1, 1'b0, 32'h0, 32'h0);
    cyc(); cyc();
    check("hold_run1", actv(1), expv(0, 31'd0, 32'd2));
    pc = 32'h0; cyc();
    pc = 32'h44; cyc(); cyc();
    check("hold_run2_pre", actv(1), expv(0, 31'd0, 32'd5));
    cyc();
    check("hold_fire", actv(1), expv(1, 31'd0, 32'd6));

    // Timeout of 10 enabled cycles, then the same with a 5-cycle en gap.
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0); cyc();
    drive(1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    for (int k = 0; k < 9; k++) cyc();
    check("to_pre", actv(1), expv(0, 31'd0, 32'd9));
    cyc();
    check("to_fire", actv(1), expv(3, 31'd0, 32'd10));
    sv = 1'b1; sa = 32'h1000; sd = 32'h1; cyc();
    check("to_sticky", actv(1), expv(3, 31'd0, 32'd10));
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0); cyc();
    for (int k = 0; k < 15; k++) begin
      drive(1'b0, !(k >= 3 && k < 8), 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
      cyc();
      if (k == 13) check("to_gap_pre", actv(1), expv(0, 31'd0, 32'd9));
    end
    check("to_gap_fire", actv(1), expv(3, 31'd0, 32'd10));

    // Disabled event sources are ignored.
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0); cyc();
    drive(1'b0, 1'b1, 32'h44, 32'h1, 1'b0, 32'h0, 32'h0);
    for (int k = 0; k < 4; k++) cyc();
    check("mode1_no_pc", actv(2), expv(0, 31'd0, 32'd4));
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0); cyc();
    drive(1'b0, 1'b1, 32'h0, 32'h0, 1'b1, 32'h1000, 32'h1); cyc();
    check("mode0_no_th", actv(3), expv(0, 31'd0, 32'd1));
    check("mode1_th", actv(2), expv(1, 31'd0, 32'd1));

    // Randomized stress against the model.
    for (int k = 0; k < 4000; k++) begin
      drive(($urandom_range(0, 24) == 0),
            ($urandom_range(0, 99) < 85),
            ($urandom_range(0, 9) < 4) ? 32'h44 : {25'd0, 5'($urandom_range(0, 31)), 2'b00},
            ($urandom_range(0, 1) == 0) ? 32'h1 : 32'($urandom_range(0, 63)),
            ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 1) == 0) ? 32'h1000 + 32'($urandom_range(0, 3))
                                        : 32'($urandom_range(0, 8191)),
            ($urandom_range(0, 2) == 0) ? 32'h1 : 32'($urandom_range(0, 31)));
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
